clk_div_prog: RTL

- Multi-channel programmable clock divider. It is the successor to the fixed-ratio divider used in the ADC test and capture path.
- Each channel produces a divided clock-level output (`clk_out`) and a one-cycle `tick` strobe, so downstream logic can use a clock-enable instead of a derived clock.
- Divide ratio and high time are runtime-programmable per channel through a valid/ready config port. New settings take effect glitch-free at the channel's period boundary.
- A global `sync` input phase-aligns all running channels.

---
 rtl/clk_div_pkg.sv | 32 +++
 rtl/clk_div_prog_if.sv | 29 ++
 rtl/clk_div_ch.sv | 80 ++++++++
 rtl/clk_div_prog.sv | 64 ++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable multi-channel clock divider.
package clk_div_pkg;

    // Width of the counter, divisor and high-time fields.
    localparam int CFG_W = 16;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
    } clk_div_cfg_t;

    typedef enum logic {
        CH_IDLE,
        CH_RUN
    } ch_state_e;

    // Make a requested setting legal. The period is at least 2 cycles, and the
    // high time is capped at the period. A high time equal to the period gives
    // a constant 1, and a high time of 0 gives a constant 0.
    function automatic clk_div_cfg_t clamp_cfg(input clk_div_cfg_t req);
        clk_div_cfg_t res;
        res = req;
        if (res.div < CFG_W'(2)) begin
            res.div = CFG_W'(2);
        end
        if (res.high > res.div) begin
            res.high = res.div;
        end
        return res;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Configuration port of the divider: a valid/ready write of one channel's settings.
interface clk_div_prog_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        output cfg_high,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_high,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: IDLE/RUN FSM, period counter, shadow/active settings
// and registered clk_out/tick outputs.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter logic [CFG_W-1:0] DEFAULT_DIV  = CFG_W'(10),
    parameter logic [CFG_W-1:0] DEFAULT_HIGH = CFG_W'(5)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sync,
    input  logic         cfg_wr,
    input  clk_div_cfg_t cfg_in,
    output logic         pending,
    output logic         clk_out,
    output logic         tick
);

    ch_state_e        state;
    logic [CFG_W-1:0] cnt;
    clk_div_cfg_t     active_cfg;
    clk_div_cfg_t     shadow_cfg;

    logic             run;
    logic             wrap;
    logic             advance;
    logic             apply;
    ch_state_e        state_nxt;
    logic [CFG_W-1:0] cnt_nxt;
    clk_div_cfg_t     cfg_nxt;

    // Next-state decode. The priority is en=0, then sync, then wrap, then increment.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
        run       = (state == CH_RUN);
        wrap      = run && (cnt == active_cfg.div - CFG_W'(1));
        // The only cycle that keeps the current period running is a plain increment.
        advance   = run && en && !sync && !wrap;
        // A pending setting is applied at every period boundary and in every IDLE cycle.
        apply     = pending && !advance;
        state_nxt = en ? CH_RUN : CH_IDLE;
        cnt_nxt   = '0;
        if (advance) begin
            cnt_nxt = cnt + CFG_W'(1);
        end
        cfg_nxt   = apply ? shadow_cfg : active_cfg;
    end

    // State, counter, settings and outputs. The outputs are computed from the
    // next state so that they line up with the counter value they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CH_IDLE;
            cnt        <= '0;
            active_cfg <= '{div: DEFAULT_DIV, high: DEFAULT_HIGH};
            // NOTE: the shadow register is reset on purpose. A reset discards a pending write and falls back to the defaults.
            shadow_cfg <= '{div: DEFAULT_DIV, high: DEFAULT_HIGH};
            pending    <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values of the others.
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            active_cfg <= cfg_nxt;
            clk_out    <= en && (cnt_nxt < cfg_nxt.high);
            tick       <= en && !(run && sync) && (cnt_nxt == cfg_nxt.div - CFG_W'(1));
            // cfg_wr needs !pending and apply needs pending, so the two never coincide.
            // A write that lands on a boundary therefore waits for the next boundary.
            if (cfg_wr) begin
                shadow_cfg <= clamp_cfg(cfg_in);
                pending    <= 1'b1;
            end else if (apply) begin
                pending    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: config demux, ready mux, sync
// fan-out and one clk_div_ch per channel.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = CFG_W,
    parameter int DEFAULT_DIV  = 10,
    parameter int DEFAULT_HIGH = 5,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    clk_div_prog_if.slave     cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [CH_W-1:0]   ch_sel;
    logic [CNT_W-1:0]  div_in;
    logic [CNT_W-1:0]  high_in;
    clk_div_cfg_t      cfg_word;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr;

    assign ch_sel   = cfg.cfg_ch;
    assign div_in   = cfg.cfg_div;
    assign high_in  = cfg.cfg_high;
    assign cfg_word = '{div: CFG_W'(div_in), high: CFG_W'(high_in)};

    // Ready reflects the selected channel's pending flag. A write strobe goes
    // only to that channel. A channel number beyond NUM_CH reports ready, and
    // the write is dropped.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        wr            = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                cfg.cfg_ready = !pending[i];
                wr[i]         = cfg.cfg_valid && !pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .DEFAULT_DIV  (CFG_W'(DEFAULT_DIV)),
            .DEFAULT_HIGH (CFG_W'(DEFAULT_HIGH))
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[g]),
            .sync    (sync),
            .cfg_wr  (wr[g]),
            .cfg_in  (cfg_word),
            .pending (pending[g]),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule
